axis_frame_gen: RTL

//  AXI-stream frame generator: the transmit-side counterpart of the frame-length monitor.
//  - Accepts a frame-length command and emits one frame of that length on an AXI-stream master.
//  - Drives a deterministic byte pattern, exact tkeep and tlast.
//  - Sits upstream of the DUT/monitor in loopback and debug setups; a monitor on its output reports frame_len == cmd_len.

---
 rtl/axis_frame_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axis_frame_gen.sv
// AXI-stream frame generator: accepts a length command and emits one frame with a byte-counting pattern.
// Optional inter-frame idle gap enabled by defining AXIS_FRAME_GEN_GAP_EN (length set by GAP_CYCLES).
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a command transfers when cmd_valid && cmd_ready, a beat when
    // m_axis_tvalid && m_axis_tready; a presented beat is held unchanged until it transfers.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

`ifdef AXIS_FRAME_GEN_GAP_EN
    localparam int GAP_LEN = GAP_CYCLES;
`else
    localparam int GAP_LEN = 0 * GAP_CYCLES;
`endif

    // Amount consumed per beat: bytes when tkeep is meaningful, otherwise one beat.
    localparam logic [LEN_WIDTH-1:0] STEP =
        (KEEP_ENABLE != 0) ? LEN_WIDTH'(KEEP_WIDTH) : LEN_WIDTH'(1);

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [7:0]            r_beat;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_last_fire;
    logic [7:0]            w_nxt_beat;
    logic [LEN_WIDTH-1:0]  w_nxt_rem;
    logic [DATA_WIDTH-1:0] w_nxt_data;
    logic [KEEP_WIDTH-1:0] w_nxt_keep;
    logic                  w_nxt_last;

    assign cmd_ready     = rst_n && (r_state == S_IDLE);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_fire        = r_tvalid && m_axis_tready;
    assign w_last_fire   = (r_state == S_SEND) && w_fire && r_tlast;

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

    // The beat to present next: beat 0 of a new command, or the successor of the current beat.
    always_comb begin
        w_nxt_beat = 8'd0;
        w_nxt_rem  = cmd_len;
        if (r_state == S_SEND) begin
            w_nxt_beat = r_beat + 8'd1;
            w_nxt_rem  = r_rem - STEP;
        end
    end

    // w_nxt_rem counts what is still owed including this beat, so lanes below it are valid.
    always_comb begin
        w_nxt_data = '0;
        w_nxt_keep = '0;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            if ((KEEP_ENABLE == 0) || (w_nxt_rem > LEN_WIDTH'(j))) begin
                w_nxt_keep[j]        = 1'b1;
                w_nxt_data[j*8 +: 8] = w_nxt_beat * 8'(KEEP_WIDTH) + 8'(j);
            end
        end
        if (KEEP_ENABLE != 0) begin
            w_nxt_last = (w_nxt_rem <= LEN_WIDTH'(KEEP_WIDTH));
        end else begin
            w_nxt_last = (w_nxt_rem == LEN_WIDTH'(1));
        end
    end

`ifdef AXIS_FRAME_GEN_GAP_EN
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    logic [GW-1:0] r_gap_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (w_last_fire) begin
            r_gap_cnt <= (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;
        end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_beat   <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A zero-length command is consumed without producing any beat.
                    if (w_accept && (cmd_len != '0)) begin
                        r_state  <= S_SEND;
                        r_rem    <= w_nxt_rem;
                        r_beat   <= w_nxt_beat;
                        r_tdata  <= w_nxt_data;
                        r_tkeep  <= w_nxt_keep;
                        r_tlast  <= w_nxt_last;
                        r_tvalid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_fire) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tdata  <= '0;
                            r_tkeep  <= '0;
                            r_state  <= (GAP_LEN > 0) ? S_GAP : S_IDLE;
                        end else begin
                            r_rem    <= w_nxt_rem;
                            r_beat   <= w_nxt_beat;
                            r_tdata  <= w_nxt_data;
                            r_tkeep  <= w_nxt_keep;
                            r_tlast  <= w_nxt_last;
                        end
                    end
                end
`ifdef AXIS_FRAME_GEN_GAP_EN
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
